hazard_ctrl_pipe: RTL

- Parametrised successor to the single-cycle bubble mux for the pipelined MIPS core.
- Owns the control-bundle pipeline registers: ID/EX (EX, M and WB fields), EX/MEM (M and WB fields) and MEM/WB (WB field).
- Contains load-use hazard detection, branch-flush bubble insertion, and a multi-cycle EX freeze for long-latency ops (mul/div).
- Drives PC and IF/ID write enables for the front end.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 25 ++
 rtl/hazard_ctrl_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/control pipeline.
//   state_e       - hazard FSM states (RUN, BUSY)
//   MEMREAD_BIT   - position of MemRead inside the M control bundle
//   *_W_DEF       - default bundle / address / latency widths
//   *_ZERO        - all-zero (bubble) bundles at the default widths
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int MEMREAD_BIT  = 1;

  localparam int EX_W_DEF     = 4;
  localparam int M_W_DEF      = 2;
  localparam int WB_W_DEF     = 2;
  localparam int REG_AW_DEF   = 5;
  localparam int LONG_LAT_DEF = 3;
  localparam int CNT_W_DEF    = 16;

  localparam logic [EX_W_DEF-1:0] EX_ZERO = '0;
  localparam logic [M_W_DEF-1:0]  M_ZERO  = '0;
  localparam logic [WB_W_DEF-1:0] WB_ZERO = '0;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detector.
//   run      in  FSM is in RUN (no detection while EX is frozen)
//   mem_read in  MemRead bit of the ID/EX M bundle (instruction in EX is a load)
//   idex_rt  in  destination (rt) of the load sitting in ID/EX
//   id_rs    in  rs of the instruction in ID
//   id_rt    in  rt of the instruction in ID
//   load_use out ID instruction consumes the load result next cycle -> stall
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              run,
  input  logic              mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              load_use
);

  // $0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use = run && mem_read && (idex_rt != '0) &&
                    ((idex_rt == id_rs) || (idex_rt == id_rt));

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: control-bundle pipeline registers (ID/EX, EX/MEM, MEM/WB)
// with load-use stall, branch-flush bubble and multi-cycle EX freeze.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   ex_ctrl_i/m_ctrl_i/wb_ctrl_i  decoded bundles from ID
//   long_op_i                     ID instruction is long-latency (mul/div)
//   id_rs_i/id_rt_i               ID source registers
//   flush_i                       branch taken in ID, discard ID instruction
//   ex_ctrl_o/exm_ctrl_o/exwb_ctrl_o  ID/EX bundles
//   m_ctrl_o/memwb_ctrl_o             EX/MEM bundles
//   wb_ctrl_o                         MEM/WB bundle
//   pc_write_o/ifid_write_o           front-end update enables
//   ex_busy_o                         FSM state (1 = BUSY); this is the FSM debug view
//
// Optional: define HAZARD_STATS_EN to add parameter CNT_W and saturating
// counters bubble_cnt_o (ID/EX bubbles from flush/load-use) and busy_cnt_o
// (BUSY cycles).
//
// Enable semantics: pc_write_o/ifid_write_o high means the front end advances
// on the next edge; low means it holds its current instruction.
module hazard_ctrl_pipe
  import hazard_pkg::*;
#(
  parameter int EX_W     = EX_W_DEF,
  parameter int M_W      = M_W_DEF,
  parameter int WB_W     = WB_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LONG_LAT = LONG_LAT_DEF
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W    = CNT_W_DEF
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [EX_W-1:0]   ex_ctrl_i,
  input  logic [M_W-1:0]    m_ctrl_i,
  input  logic [WB_W-1:0]   wb_ctrl_i,
  input  logic              long_op_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              flush_i,
  output logic [EX_W-1:0]   ex_ctrl_o,
  output logic [M_W-1:0]    exm_ctrl_o,
  output logic [WB_W-1:0]   exwb_ctrl_o,
  output logic [M_W-1:0]    m_ctrl_o,
  output logic [WB_W-1:0]   memwb_ctrl_o,
  output logic [WB_W-1:0]   wb_ctrl_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ex_busy_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  busy_cnt_o
`endif
);

  localparam int CNT_BITS = $clog2(LONG_LAT) + 1;

  localparam logic [EX_W-1:0] EX_BUB = EX_W'(EX_ZERO);
  localparam logic [M_W-1:0]  M_BUB  = M_W'(M_ZERO);
  localparam logic [WB_W-1:0] WB_BUB = WB_W'(WB_ZERO);

  state_e              state;
  logic [CNT_BITS-1:0] cnt;
  logic [REG_AW-1:0]   idex_rt;
  logic                idex_long;
  logic                load_use;
  logic                bubble;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_detect (
    .run      (state == RUN),
    .mem_read (exm_ctrl_o[MEMREAD_BIT]),
    .idex_rt  (idex_rt),
    .id_rs    (id_rs_i),
    .id_rt    (id_rt_i),
    .load_use (load_use)
  );

  // A flush outranks load_use: the dependent instruction is being discarded.
  assign bubble = (state == RUN) && (flush_i || load_use);

  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    if (state == BUSY) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (!flush_i && load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end
  end

  assign ex_busy_o = (state == BUSY);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= RUN;
      cnt          <= '0;
      ex_ctrl_o    <= EX_BUB;
      exm_ctrl_o   <= M_BUB;
      exwb_ctrl_o  <= WB_BUB;
      idex_rt      <= '0;
      idex_long    <= 1'b0;
      m_ctrl_o     <= M_BUB;
      memwb_ctrl_o <= WB_BUB;
      wb_ctrl_o    <= WB_BUB;
    end else begin
      wb_ctrl_o <= memwb_ctrl_o;
      case (state)
        BUSY: begin
          // ID/EX holds the long op; EX produces nothing downstream.
          m_ctrl_o     <= M_BUB;
          memwb_ctrl_o <= WB_BUB;
          cnt          <= cnt - CNT_BITS'(1);
          // idex_long is always set while BUSY; it also guards exit.
          if (cnt == CNT_BITS'(1) || !idex_long) begin
            state <= RUN;
          end
        end
        default: begin
          m_ctrl_o     <= exm_ctrl_o;
          memwb_ctrl_o <= exwb_ctrl_o;
          if (bubble) begin
            ex_ctrl_o   <= EX_BUB;
            exm_ctrl_o  <= M_BUB;
            exwb_ctrl_o <= WB_BUB;
            idex_rt     <= '0;
            idex_long   <= 1'b0;
          end else begin
            ex_ctrl_o   <= ex_ctrl_i;
            exm_ctrl_o  <= m_ctrl_i;
            exwb_ctrl_o <= wb_ctrl_i;
            idex_rt     <= id_rt_i;
            idex_long   <= long_op_i;
            // The RUN cycle of the op counts toward LONG_LAT, hence -1.
            if (long_op_i && (LONG_LAT > 1)) begin
              state <= BUSY;
              cnt   <= CNT_BITS'(LONG_LAT - 1);
            end
          end
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
      busy_cnt_o   <= '0;
    end else begin
      if (bubble && (bubble_cnt_o != '1)) begin
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      end
      if ((state == BUSY) && (busy_cnt_o != '1)) begin
        busy_cnt_o <= busy_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule
